// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder for the yChip core: valid/ready fetch handshake,
// a programmable number of wait states, a side load port and a saturating fetch counter.
module imem_fetch_responder #(
    parameter int          ADDR_W      = 8,
    parameter logic [31:0] BASE        = 32'h80,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic [31:0]       req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    input  logic              rsp_ready,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    output logic              busy,
    output logic [15:0]       fetch_cnt
);

    localparam int         DEPTH     = 2 ** ADDR_W;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                err_q, err_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic [15:0]         fetch_cnt_q, fetch_cnt_d;

    logic [31:0]         mem [DEPTH];

    logic [29:0]         req_word;
    logic [ADDR_W-1:0]   req_idx;
    logic                req_err;
    logic                load_rsp;
    logic [ADDR_W-1:0]   load_idx;
    logic                load_err;

    // Word offset from BASE; anything past the array depth shows up as high bits.
    assign req_word = 30'((req_addr - BASE) >> 2);
    assign req_idx  = req_word[ADDR_W-1:0];
    assign req_err  = (req_addr[1:0] != 2'b00) || (req_addr < BASE) || ((req_word >> ADDR_W) != 30'd0);

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        idx_d       = idx_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        fetch_cnt_d = fetch_cnt_q;
        load_rsp    = 1'b0;
        load_idx    = idx_q;
        load_err    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    idx_d = req_idx;
                    err_d = req_err;
                    if (WAIT_CYCLES > 0) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_INIT;
                    end else begin
                        load_rsp = 1'b1;
                        load_idx = req_idx;
                        load_err = req_err;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    load_rsp = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_data_d  = 32'h0;
                    rsp_err_d   = 1'b0;
                    fetch_cnt_d = (fetch_cnt_q == 16'hFFFF) ? fetch_cnt_q : fetch_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The array is read before this edge's load-port write lands.
        if (load_rsp) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = load_err;
            rsp_data_d  = load_err ? 32'h0 : mem[load_idx];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= 4'd0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_err_q   <= 1'b0;
            fetch_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    // Program storage keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Self-checking bench for imem_fetch_responder: a 2-wait-state instance (unit 0)
// and a zero-wait instance (unit 1), checked against tables and a behavioural model.
module tb_imem_fetch_responder;

    localparam int          ADDR_W = 8;
    localparam int          DEPTH  = 256;
    localparam logic [31:0] BASE   = 32'h80;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic              req_valid [2];
    logic [31:0]       req_addr  [2];
    logic              req_ready [2];
    logic              rsp_valid [2];
    logic [31:0]       rsp_data  [2];
    logic              rsp_err   [2];
    logic              rsp_ready [2];
    logic              ld_en     [2];
    logic [ADDR_W-1:0] ld_addr   [2];
    logic [31:0]       ld_data   [2];
    logic              busy      [2];
    logic [15:0]       fetch_cnt [2];

    imem_fetch_responder #(.ADDR_W(ADDR_W), .BASE(BASE), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[0]), .req_addr(req_addr[0]), .req_ready(req_ready[0]),
        .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
        .rsp_ready(rsp_ready[0]),
        .ld_en(ld_en[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0]),
        .busy(busy[0]), .fetch_cnt(fetch_cnt[0])
    );

    imem_fetch_responder #(.ADDR_W(ADDR_W), .BASE(BASE), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[1]), .req_addr(req_addr[1]), .req_ready(req_ready[1]),
        .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
        .rsp_ready(rsp_ready[1]),
        .ld_en(ld_en[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1]),
        .busy(busy[1]), .fetch_cnt(fetch_cnt[1])
    );

    logic [31:0] model_mem [2][DEPTH];
    int          model_cnt [2];
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        bit          doLoad;
        logic [7:0]  ldIdx;
        logic [31:0] ldWord;
        logic [31:0] addr;
        int          stall;
        logic [31:0] expData;
        logic        expErr;
    } vec_t;

    vec_t vecs [10];

    function automatic int waitsOf(input int u);
        return (u == 0) ? 2 : 0;
    endfunction

    // Fetch legality straight from the address rules, in 64-bit arithmetic.
    function automatic logic modelErr(input logic [31:0] a);
        longint off;
        if (a[1:0] != 2'b00) return 1'b1;
        if (a < BASE) return 1'b1;
        off = (longint'({32'd0, a}) - longint'({32'd0, BASE})) / 4;
        return (off >= DEPTH);
    endfunction

    function automatic int modelIdx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checkOutput(name, 32'(act), 32'(exp));
    endtask

    task automatic ldWrite(input int u, input int idx, input logic [31:0] word);
        ld_en[u]   = 1'b1;
        ld_addr[u] = ADDR_W'(idx);
        ld_data[u] = word;
        @(posedge clk); #1;
        ld_en[u] = 1'b0;
        model_mem[u][idx] = word;
    endtask

    // One full fetch: request, wait for rsp_valid, optional backpressure, handshake.
    task automatic applyStimulus(input int u, input logic [31:0] addr, input int stall, input bit holdRdy,
                                 output logic [31:0] data, output logic err, output int lat);
        checkBit("req_ready_before", req_ready[u], 1'b1);
        req_valid[u] = 1'b1;
        req_addr[u]  = addr;
        rsp_ready[u] = holdRdy;
        @(posedge clk); #1;
        lat = 1;
        req_valid[u] = 1'b0;
        req_addr[u]  = $urandom;
        while (rsp_valid[u] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        data = rsp_data[u];
        err  = rsp_err[u];
        if (!holdRdy) begin
            for (int i = 0; i < stall; i++) begin
                req_valid[u] = 1'b1;
                @(posedge clk); #1;
                checkBit("stall_valid", rsp_valid[u], 1'b1);
                checkOutput("stall_data", rsp_data[u], data);
                checkBit("stall_err", rsp_err[u], err);
                checkBit("stall_req_ready", req_ready[u], 1'b0);
                checkBit("stall_busy", busy[u], 1'b1);
            end
            rsp_ready[u] = 1'b1;
        end
        @(posedge clk); #1;
        req_valid[u] = 1'b0;
        rsp_ready[u] = 1'b0;
        checkBit("post_rsp_valid", rsp_valid[u], 1'b0);
        checkOutput("post_rsp_data", rsp_data[u], 32'h0);
        checkBit("post_rsp_err", rsp_err[u], 1'b0);
        checkBit("post_req_ready", req_ready[u], 1'b1);
    endtask

    task automatic fetchAndCheck(input int u, input logic [31:0] addr, input int stall, input bit holdRdy);
        logic [31:0] d;
        logic        e;
        int          lat;
        logic        expE;
        logic [31:0] expD;
        expE = modelErr(addr);
        expD = expE ? 32'h0 : model_mem[u][modelIdx(addr)];
        applyStimulus(u, addr, stall, holdRdy, d, e, lat);
        model_cnt[u] = (model_cnt[u] < 65535) ? model_cnt[u] + 1 : 65535;
        checkOutput($sformatf("latency u%0d a%h", u, addr), 32'(lat), 32'(waitsOf(u) + 1));
        checkOutput($sformatf("rsp_data u%0d a%h", u, addr), d, expD);
        checkBit($sformatf("rsp_err u%0d a%h", u, addr), e, expE);
        checkOutput($sformatf("fetch_cnt u%0d", u), 32'(fetch_cnt[u]), 32'(model_cnt[u]));
    endtask

    task automatic finishRsp(input int u);
        rsp_ready[u] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[u] = 1'b0;
        model_cnt[u] = (model_cnt[u] < 65535) ? model_cnt[u] + 1 : 65535;
        checkBit("finish_rsp_valid", rsp_valid[u], 1'b0);
        checkOutput("finish_fetch_cnt", 32'(fetch_cnt[u]), 32'(model_cnt[u]));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic        e;
        int          lat;
        logic [31:0] addr;
        int          u;
        int          kind;
        int          idx;

        vecs[0] = '{1'b1, 8'd0,   32'h2008000A, 32'h80,        0, 32'h2008000A, 1'b0};
        vecs[1] = '{1'b1, 8'd1,   32'hAC080000, 32'h84,        5, 32'hAC080000, 1'b0};
        vecs[2] = '{1'b0, 8'd0,   32'h0,        32'h82,        0, 32'h0,        1'b1};
        vecs[3] = '{1'b0, 8'd0,   32'h0,        32'h7C,        1, 32'h0,        1'b1};
        vecs[4] = '{1'b0, 8'd0,   32'h0,        32'h480,       0, 32'h0,        1'b1};
        vecs[5] = '{1'b1, 8'd255, 32'hCAFEF00D, 32'h47C,       2, 32'hCAFEF00D, 1'b0};
        vecs[6] = '{1'b0, 8'd0,   32'h0,        32'h47E,       0, 32'h0,        1'b1};
        vecs[7] = '{1'b0, 8'd0,   32'h0,        32'h0,         0, 32'h0,        1'b1};
        vecs[8] = '{1'b0, 8'd0,   32'h0,        32'hFFFFFFFC,  0, 32'h0,        1'b1};
        vecs[9] = '{1'b0, 8'd0,   32'h0,        32'h81,        3, 32'h0,        1'b1};

        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0; req_addr[k] = 32'h0; rsp_ready[k] = 1'b0;
            ld_en[k] = 1'b0; ld_addr[k] = '0; ld_data[k] = 32'h0;
            model_cnt[k] = 0;
        end

        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checkBit("reset_rsp_valid", rsp_valid[k], 1'b0);
            checkOutput("reset_rsp_data", rsp_data[k], 32'h0);
            checkBit("reset_rsp_err", rsp_err[k], 1'b0);
            checkBit("reset_busy", busy[k], 1'b0);
            checkOutput("reset_fetch_cnt", 32'(fetch_cnt[k]), 32'h0);
            checkBit("reset_req_ready", req_ready[k], 1'b1);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < 2; k++) begin
                ld_en[k] = 1'b1; ld_addr[k] = ADDR_W'(i); ld_data[k] = $urandom;
                model_mem[k][i] = ld_data[k];
            end
            @(posedge clk); #1;
        end
        for (int k = 0; k < 2; k++) ld_en[k] = 1'b0;

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].doLoad) ldWrite(0, int'(vecs[i].ldIdx), vecs[i].ldWord);
            applyStimulus(0, vecs[i].addr, vecs[i].stall, 1'b0, d, e, lat);
            model_cnt[0]++;
            checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
            checkOutput($sformatf("vec%0d rsp_data", i), d, vecs[i].expData);
            checkBit($sformatf("vec%0d rsp_err", i), e, vecs[i].expErr);
            checkOutput($sformatf("vec%0d fetch_cnt", i), 32'(fetch_cnt[0]), 32'(i + 1));
        end

        // Load one edge before the sampling edge: the new word is returned.
        req_valid[0] = 1'b1; req_addr[0] = 32'h88;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        ld_en[0] = 1'b1; ld_addr[0] = 8'd2; ld_data[0] = 32'h11111111;
        @(posedge clk); #1;
        ld_en[0] = 1'b0; model_mem[0][2] = 32'h11111111;
        checkBit("coll_early_notyet", rsp_valid[0], 1'b0);
        @(posedge clk); #1;
        checkBit("coll_early_valid", rsp_valid[0], 1'b1);
        checkOutput("coll_early_data", rsp_data[0], 32'h11111111);
        finishRsp(0);

        // Load on the sampling edge itself: the old word is returned.
        req_valid[0] = 1'b1; req_addr[0] = 32'h88;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        ld_en[0] = 1'b1; ld_addr[0] = 8'd2; ld_data[0] = 32'h22222222;
        @(posedge clk); #1;
        ld_en[0] = 1'b0; model_mem[0][2] = 32'h22222222;
        checkBit("coll_same_valid", rsp_valid[0], 1'b1);
        checkOutput("coll_same_data", rsp_data[0], 32'h11111111);
        finishRsp(0);
        fetchAndCheck(0, 32'h88, 0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            u    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 9));
            idx  = int'($urandom_range(0, 255));
            if (kind < 6)       addr = BASE + 32'(4 * idx);
            else if (kind == 6) addr = BASE + 32'(4 * idx) + 32'($urandom_range(1, 3));
            else if (kind == 7) addr = 32'($urandom_range(0, 127));
            else if (kind == 8) addr = BASE + 32'h400 + 32'(4 * $urandom_range(0, 1000));
            else                addr = $urandom;
            if ($urandom_range(0, 3) == 0) ldWrite(u, idx, $urandom);
            fetchAndCheck(u, addr, int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
        end

        // Reset while waiting: the fetch is abandoned and never answered.
        req_valid[0] = 1'b1; req_addr[0] = 32'h80;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        checkBit("midrst_busy_before", busy[0], 1'b1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        checkBit("midrst_rsp_valid", rsp_valid[0], 1'b0);
        checkBit("midrst_busy", busy[0], 1'b0);
        checkBit("midrst_req_ready", req_ready[0], 1'b1);
        checkOutput("midrst_fetch_cnt", 32'(fetch_cnt[0]), 32'h0);
        model_cnt[0] = 0;
        model_cnt[1] = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checkBit("midrst_no_stale", rsp_valid[0], 1'b0);
        end
        fetchAndCheck(0, 32'h80, 0, 1'b0);

        for (int i = 0; i < 43; i++) begin
            fetchAndCheck(1, BASE + 32'(4 * i), 0, 1'b1);
        end
        checkOutput("zero_wait_cnt43", 32'(fetch_cnt[1]), 32'd43);

        @(negedge clk);
        force dut_z.fetch_cnt_q = 16'hFFFE;
        #1;
        release dut_z.fetch_cnt_q;
        model_cnt[1] = 65534;
        fetchAndCheck(1, 32'h90, 0, 1'b1);
        checkOutput("sat_reach", 32'(fetch_cnt[1]), 32'h0000FFFF);
        fetchAndCheck(1, 32'h82, 0, 1'b1);
        checkOutput("sat_hold", 32'(fetch_cnt[1]), 32'h0000FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
Instruction-memory responder serving fetches from the single-cycle core (yChip) over a valid/ready request and response handshake, with a configurable number of wait states.
- A load port lets the bench or a boot loader write program words before or during execution.
- Maintains a saturating count of completed fetches for the bench's trace display.

Parameters:
ADDR_W, 8, word-index width; memory depth = 2**ADDR_W 32-bit words
BASE, 32'h80, byte address of word 0 (matches the core's entry point)
WAIT_CYCLES, 2, wait states inserted between request accept and response (0..15)

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  core presents a fetch
req_addr  input  32  fetch byte address
req_ready  output  1  responder can accept a fetch
rsp_valid  output  1  response data valid
rsp_data  output  32  instruction word
rsp_err  output  1  fetch was misaligned or out of range
rsp_ready  input  1  core accepts the response
ld_en  input  1  load-port write strobe
ld_addr  input  ADDR_W  load word index
ld_data  input  32  load word
busy  output  1  high in WAIT or RESP
fetch_cnt  output  16  completed responses, saturating

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, fetch_cnt=0, wait counter=0, req_ready=1.
  - Memory array is not reset.
  - Reset mid-transaction abandons it with no response.
- FSM states: IDLE, WAIT, RESP. req_ready=1 only in IDLE; busy = not IDLE.
- IDLE:
  - On req_valid & req_ready the request is accepted: address is latched and the error flag is computed.
  - err = (req_addr[1:0]!=0) | (req_addr<BASE) | (((req_addr-BASE)>>2) >= 2**ADDR_W).
  - Next state is WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0, else RESP.
- WAIT: counter decrements each edge. The edge on which counter==0 moves to RESP.
- Latency: rsp_valid rises after exactly WAIT_CYCLES+1 rising edges, counting the accepting edge.
- Entry to RESP:
  - rsp_data is registered on that edge: mem[word index], or 32'h0 if err.
  - rsp_err = err.
- Load port:
  - ld_en writes mem[ld_addr] on any edge, in any state.
  - A write on the same edge that samples rsp_data returns the old word (read-before-write).
  - A write on an earlier edge returns the new word.
- RESP:
  - rsp_valid, rsp_data and rsp_err are held stable until rsp_valid & rsp_ready.
  - On that edge: rsp_valid=0, rsp_err=0, rsp_data=0, state IDLE.
  - Also on that edge, fetch_cnt increments (saturates at 16'hFFFF); error responses are counted too.
- Back-to-back: a new request can only be accepted on the edge after returning to IDLE. req_ready is low during RESP, including the handshake cycle, so at most one request is in flight.
- req_addr and req_valid are ignored outside IDLE.
- rsp_ready is ignored outside RESP; rsp_ready held high has no effect until rsp_valid.

Test Plan:
- Reset then load: reset_n low 2 cycles, outputs zero, req_ready=1; load mem[0]=32'h2008000A via the load port; fetch 32'h80 with rsp_ready=1 -> rsp_valid after 3 edges, rsp_data=32'h2008000A, rsp_err=0, fetch_cnt=1.
- Backpressure: fetch 32'h84 with mem[1]=32'hAC080000, rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable all 5 cycles, req_ready=0; raise rsp_ready -> IDLE next edge, fetch_cnt increments.
- Errors:
  - Fetch 32'h82 -> rsp_err=1, rsp_data=0.
  - Fetch 32'h7C -> rsp_err=1.
  - Fetch BASE+4*256 (32'h480) with ADDR_W=8 -> rsp_err=1.
  - Each error response increments fetch_cnt.
- Load collision: during WAIT of a fetch to 32'h88, write mem[2]=32'h11111111 one edge before the sampling edge -> 32'h11111111 returned. Write 32'h22222222 on the sampling edge itself -> 32'h11111111 returned; a refetch returns 32'h22222222.
- Reset mid-operation: assert reset_n low during WAIT -> rsp_valid stays 0, state IDLE, fetch_cnt=0, no stale response after release.
- WAIT_CYCLES=0 build:
  - 43 sequential fetches from 32'h80 with rsp_ready=1 -> each rsp_valid one edge after accept, fetch_cnt=43.
  - Forcing the count to 16'hFFFF then one more fetch leaves fetch_cnt at 16'hFFFF.
